// File: rtl/md_ctrl_if.sv
// Handshake between the execute-stage md_ctrl sequencer and the shared multiplier/divider unit.
`timescale 1ns/1ps
interface md_ctrl_if;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        md_ready;
    logic [31:0] md_result;
    logic        md_exception;

    modport master (
        output ctrl_mult, ctrl_div,
        input  md_ready, md_result, md_exception
    );

    modport slave (
        input  ctrl_mult, ctrl_div,
        output md_ready, md_result, md_exception
    );
endinterface

// File: rtl/md_ctrl.sv
// Execute-stage sequencer for the shared multicycle mul/div unit: issue, stall, capture, single-cycle result strobe.
// Optional RUN watchdog enabled by defining MD_TIMEOUT_EN (aborts to DONE with res=0, res_ovf=1 after TIMEOUT cycles).
`timescale 1ns/1ps
module md_ctrl #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      dx_ins,
    input  logic             flush,
    md_ctrl_if.master        md,
    output logic             stall,
    output logic             res_valid,
    output logic [31:0]      res,
    output logic             res_ovf,
    output logic [CNT_W-1:0] busy_cnt
);

    if ((64'(1) << CNT_W) <= 64'(TIMEOUT)) begin : gCfgCheck
        $error("md_ctrl: CNT_W too narrow to count to TIMEOUT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT state, stateNext;

    logic isMul, isDiv, isMd;
    logic firstRun;
    logic launch, capture, abort, stallRaw;
    logic expire;

    always_comb begin
        isMul = (dx_ins[31:27] == 5'b00000) && (dx_ins[6:2] == 5'b00110);
        isDiv = (dx_ins[31:27] == 5'b00000) && (dx_ins[6:2] == 5'b00111);
        isMd  = isMul | isDiv;
    end

    // The start pulse marks the first RUN cycle; a stale md_ready there belongs to the previous op.
    assign firstRun = md.ctrl_mult | md.ctrl_div;

`ifdef MD_TIMEOUT_EN
    assign expire = (busy_cnt == CNT_W'(TIMEOUT));
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        stallRaw  = 1'b0;
        res_valid = 1'b0;
        launch    = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (isMd && !flush) begin
                    stallRaw  = 1'b1;
                    launch    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                stallRaw = 1'b1;
                if (flush) begin
                    abort     = 1'b1;
                    stateNext = IDLE;
                end else if (md.md_ready && !firstRun) begin
                    capture   = 1'b1;
                    stateNext = DONE;
                end else if (expire) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Reset forces stall low even while a mul/div sits in DX.
    assign stall = stallRaw & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md.ctrl_mult <= 1'b0;
            md.ctrl_div  <= 1'b0;
            res          <= '0;
            res_ovf      <= 1'b0;
            busy_cnt     <= '0;
        end else begin
            md.ctrl_mult <= launch & isMul;
            md.ctrl_div  <= launch & isDiv;

            if (capture) begin
                res     <= md.md_result;
                res_ovf <= md.md_exception;
            end else if (state == RUN && !flush && expire) begin
                res     <= '0;
                res_ovf <= 1'b1;
            end

            if (launch) begin
                busy_cnt <= CNT_W'(1);
            end else if (abort || state == DONE) begin
                busy_cnt <= '0;
            end else if (state == RUN && stateNext == RUN && busy_cnt != '1) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
Execute-stage sequencer for the shared multicycle multiplier/divider unit.
- Detects a mul/div instruction sitting in the DX latch, issues a one-cycle start pulse to the unit and holds stall asserted while the unit runs.
- Captures the unit's result and overflow so the XM latch receives them on the single advance cycle.
- Sits between the DX latch output, the multdiv unit, the pipeline enable logic (PC/FD/DX latch enables) and the XM latch o/ovf inputs.

Parameters:
- TIMEOUT, 40, max RUN cycles before forced abort (timeout feature only).
- CNT_W, 6, width of the busy cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- dx_ins  input  32  instruction in the DX latch; opcode [31:27], aluop [6:2].
- flush  input  1  branch/jump squash of the DX instruction.
- md_ready  input  1  unit result valid; level, held until next start.
- md_result  input  32  unit result.
- md_exception  input  1  unit div-by-zero/overflow flag, valid with md_ready.
- ctrl_mult  output  1  one-cycle multiply start pulse.
- ctrl_div  output  1  one-cycle divide start pulse.
- stall  output  1  freeze PC/FD/DX latches; insert nop into XM.
- res_valid  output  1  result strobe to the XM latch mux.
- res  output  32  captured result.
- res_ovf  output  1  captured exception; goes to the XM ovf input.
- busy_cnt  output  CNT_W  cycles spent in RUN for the current op.

Behaviour:
- Decode: is_mul = dx_ins[31:27]==5'b00000 && dx_ins[6:2]==5'b00110; is_div is the same with aluop 5'b00111; md = is_mul|is_div.
- States: IDLE, RUN, DONE; 2-bit state register. Asynchronous reset: state=IDLE, all outputs 0, res=0, busy_cnt=0.
- IDLE:
  - stall = md & ~flush (combinational).
  - On a clock edge with md & ~flush: go to RUN; register op type; ctrl_mult/ctrl_div asserted (registered) during the first RUN cycle only.
  - Otherwise stay in IDLE.
- RUN:
  - stall = 1; busy_cnt increments each cycle, starting at 1 in the first RUN cycle.
  - md_ready is ignored in the first RUN cycle, so a stale ready from the previous op is never taken.
  - md_ready on a later cycle: res <= md_result, res_ovf <= md_exception; go to DONE.
  - flush in RUN: abort to IDLE; no res_valid; res/res_ovf unchanged; busy_cnt cleared.
  - flush and md_ready in the same cycle: flush wins.
- DONE:
  - stall = 0, res_valid = 1 for exactly one cycle; the pipeline advances and the mul/div moves DX->XM with res.
  - Always returns to IDLE; busy_cnt cleared.
  - md is not re-evaluated in DONE, so the same instruction is never issued twice.
- Back-to-back mul/div: the second instruction is detected in IDLE on the cycle after DONE. Minimum latency per op = unit latency + 2 cycles.
- res and res_ovf hold their value until the next capture.
- ctrl_mult and ctrl_div are never asserted together.
- Reset mid-RUN: immediate IDLE, no pulse, stall drops asynchronously.
- busy_cnt saturates at 2^CNT_W-1 and does not wrap.

Optional Feature:
- MD_TIMEOUT_EN defined: when busy_cnt reaches TIMEOUT in RUN without md_ready, go to DONE with res=0 and res_ovf=1, so the pipeline reports an exception instead of hanging.
- MD_TIMEOUT_EN undefined: RUN waits indefinitely for md_ready; no timeout logic is present.

Test Plan:
1. Reset: reset_n=0 mid-RUN -> next sample shows state IDLE, stall=0, ctrl_*=0, res=0.
2. dx_ins mul (opcode 0, aluop 00110), unit model ready after 32 cycles with result 0x00000015 -> ctrl_mult high for exactly 1 cycle; stall high 33 cycles; res_valid 1 cycle with res=0x15, res_ovf=0.
3. div by zero, model ready after 5 cycles with md_exception=1 -> ctrl_div single pulse; res_ovf=1 on res_valid.
4. flush asserted on RUN cycle 3 -> IDLE next cycle, no res_valid, stall drops, res unchanged.
5. Two consecutive mul instructions -> two separate ctrl_mult pulses; second pulse issued 2 cycles after the first res_valid; no duplicate issue.
6. MD_TIMEOUT_EN defined, TIMEOUT=40, model never ready -> res_valid on the cycle after busy_cnt hits 40, with res=0 and res_ovf=1; without the macro, stall stays high for 100+ cycles.
